// File: rtl/clc_encoder_pipe.sv
// Two-stage CLC encoder: 16-bit data in, 32-bit codeword (data + 16 redundancy bits) out,
// with valid/ready on both sides and a one-shot XOR fault-injection mask.
module clc_encoder_pipe #(
   parameter int INJ_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:15]      data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:31]      code_out,
   input  logic             inj_arm,
   input  logic [0:31]      inj_mask,
   output logic             inj_pending,
   output logic [CNT_W-1:0] word_cnt
);

   logic        s1_valid;
   logic        s2_valid;
   logic [0:31] s1_code;
   logic [0:31] pend_mask;
   logic [0:15] r;
   logic        s2_adv;
   logic        s1_adv;
   logic        accept;
   logic        arm;
   logic        out_hs;
   logic        consume;

   always_comb begin
      r     = '0;
      r[0]  = data_in[0] ^ data_in[2]  ^ data_in[5]  ^ data_in[7];
      r[1]  = data_in[9] ^ data_in[11] ^ data_in[12] ^ data_in[14];
      r[2]  = data_in[1] ^ data_in[3]  ^ data_in[4]  ^ data_in[6];
      r[3]  = data_in[8] ^ data_in[10] ^ data_in[13] ^ data_in[15];
      r[4]  = data_in[0] ^ data_in[1]  ^ data_in[4]  ^ data_in[5];
      r[5]  = data_in[10] ^ data_in[11] ^ data_in[14] ^ data_in[15];
      r[6]  = data_in[2] ^ data_in[3]  ^ data_in[6]  ^ data_in[7];
      r[7]  = data_in[8] ^ data_in[9]  ^ data_in[12] ^ data_in[13];
      r[8]  = data_in[0] ^ data_in[8];
      r[9]  = data_in[4] ^ data_in[12];
      r[10] = data_in[1] ^ data_in[9];
      r[11] = data_in[5] ^ data_in[13];
      r[12] = data_in[2] ^ data_in[10];
      r[13] = data_in[6] ^ data_in[14];
      r[14] = data_in[3] ^ data_in[11];
      r[15] = data_in[7] ^ data_in[15];
   end

   always_comb begin
      s2_adv   = !s2_valid || out_ready;
      s1_adv   = s1_valid && s2_adv;
      in_ready = !s1_valid || s2_adv;
      accept   = in_valid && in_ready;
      out_hs   = s2_valid && out_ready;
      arm      = inj_arm && (INJ_EN != 0);
      consume  = s1_adv && inj_pending;
   end

   assign out_valid = s2_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_code  <= {data_in, r};
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // The advancing word always sees the mask held before this edge, so a
   // same-cycle re-arm only affects the following word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         code_out <= '0;
      end else if (s1_adv) begin
         s2_valid <= 1'b1;
         code_out <= consume ? (s1_code ^ pend_mask) : s1_code;
      end else if (out_hs) begin
         s2_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_pending <= 1'b0;
         pend_mask   <= '0;
      end else if (arm) begin
         inj_pending <= 1'b1;
         pend_mask   <= inj_mask;
      end else if (consume) begin
         inj_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
      end else if (out_hs) begin
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_clc_encoder_pipe.sv
// Scoreboard bench for clc_encoder_pipe: driver pushes expected codewords,
// a negedge monitor pops and compares on every output handshake.
module tb_clc_encoder_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [0:15] data_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [0:31] code_out;
   logic        inj_arm = 1'b0;
   logic [0:31] inj_mask = '0;
   logic        inj_pending;
   logic [15:0] word_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          bp_mode = 0;
   int          hs_cnt = 0;
   logic [31:0] exp_q[$];
   int          pop_cyc[$];
   logic        stall = 1'b0;
   logic [31:0] stall_code = '0;

   // Redundancy bit k is the parity of the data bits listed here (bit 0 = MSB).
   int grp[16][4] = '{
      '{0, 2, 5, 7}, '{9, 11, 12, 14}, '{1, 3, 4, 6}, '{8, 10, 13, 15},
      '{0, 1, 4, 5}, '{10, 11, 14, 15}, '{2, 3, 6, 7}, '{8, 9, 12, 13},
      '{0, 8, -1, -1}, '{4, 12, -1, -1}, '{1, 9, -1, -1}, '{5, 13, -1, -1},
      '{2, 10, -1, -1}, '{6, 14, -1, -1}, '{3, 11, -1, -1}, '{7, 15, -1, -1}
   };

   clc_encoder_pipe #(.INJ_EN(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
      .code_out(code_out), .inj_arm(inj_arm), .inj_mask(inj_mask),
      .inj_pending(inj_pending), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_code(input logic [15:0] d);
      logic [15:0] mask;
      logic [15:0] red;
      red = '0;
      for (int k = 0; k < 16; k++) begin
         mask = '0;
         for (int j = 0; j < 4; j++)
            if (grp[k][j] >= 0) mask[15 - grp[k][j]] = 1'b1;
         red[15 - k] = ($countones(d & mask) % 2) == 1;
      end
      return {d, red};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (bp_mode == 0) out_ready = 1'b1;
      else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b0;
   end

   // Monitor
   always begin
      @(negedge clk);
      if (rst) begin
         stall = 1'b0;
      end else begin
         check("word_cnt", 32'(word_cnt), 32'(hs_cnt[15:0]));
         if (stall) check("hold", {31'b0, out_valid} == 32'd1 ? code_out : 32'hx, stall_code);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", code_out, 32'hDEADBEEF ^ code_out);
            else check("code_out", code_out, exp_q.pop_front());
            hs_cnt++;
            pop_cyc.push_back(cyc);
         end
         stall = out_valid && !out_ready;
         stall_code = code_out;
      end
   end

   task automatic send(input logic [15:0] d, input logic [31:0] m, output int tries);
      logic acc;
      tries = 0;
      in_valid = 1'b1;
      data_in = d;
      acc = 1'b0;
      while (!acc && tries < 200) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) exp_q.push_back(ref_code(d) ^ m);
         @(posedge clk);
         #1;
         tries++;
      end
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 32'(tries), 32'd0);
   endtask

   task automatic arm(input logic [31:0] m);
      inj_arm = 1'b1;
      inj_mask = m;
      @(posedge clk);
      #1;
      inj_arm = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t;
      int t2;
      int t3;
      logic [15:0] w;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_code_out", code_out, 32'd0);
      check("rst_inj_pending", {31'b0, inj_pending}, 32'd0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Zero word, two-cycle latency
      send(16'h0000, 32'h0, t);
      @(negedge clk);
      check("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
      drain();
      check("word_cnt_after_first", 32'(word_cnt), 32'd1);

      // Back-to-back words at full throughput
      pop_cyc.delete();
      send(16'h8000, 32'h0, t);
      send(16'h0400, 32'h0, t2);
      send(16'hFFFF, 32'h0, t3);
      check("b2b_in_ready", 32'(t + t2 + t3), 32'd3);
      drain();
      check("b2b_count", 32'(pop_cyc.size()), 32'd3);
      if (pop_cyc.size() == 3) begin
         check("b2b_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
         check("b2b_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
      end
      check("ref_8000", ref_code(16'h8000), 32'h80008880);

      // Random stream under random backpressure
      bp_mode = 1;
      for (int i = 0; i < 8; i++) begin
         w = 16'($urandom);
         send(w, 32'h0, t);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      bp_mode = 0;
      @(posedge clk);
      #1;

      // One-shot injection
      arm(32'h00000001);
      @(negedge clk);
      check("inj_pending_armed", {31'b0, inj_pending}, 32'd1);
      @(posedge clk);
      #1;
      send(16'h0000, 32'h00000001, t);
      @(negedge clk);
      check("inj_pending_before_adv", {31'b0, inj_pending}, 32'd1);
      @(negedge clk);
      check("inj_pending_after_adv", {31'b0, inj_pending}, 32'd0);
      @(posedge clk);
      #1;
      send(16'h0000, 32'h0, t);
      drain();

      // Re-arm in the same cycle a pending mask is consumed
      arm(32'h80000000);
      send(16'h0000, 32'h80000000, t);
      arm(32'h00010000);
      @(negedge clk);
      check("inj_pending_rearm", {31'b0, inj_pending}, 32'd1);
      @(posedge clk);
      #1;
      send(16'h0000, 32'h00010000, t);
      drain();
      check("inj_pending_final", {31'b0, inj_pending}, 32'd0);

      // Reset with both stages full and output stalled
      bp_mode = 2;
      @(posedge clk);
      #1;
      send(16'h1111, 32'h0, t);
      send(16'h2222, 32'h0, t);
      arm(32'hFFFFFFFF);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_word_cnt", 32'(word_cnt), 32'd0);
      check("arst_inj_pending", {31'b0, inj_pending}, 32'd0);
      exp_q.delete();
      hs_cnt = 0;
      bp_mode = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      send(16'hA5C3, 32'h0, t);
      @(negedge clk);
      check("post_rst_lat1", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check("post_rst_lat2", {31'b0, out_valid}, 32'd1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clc_encoder_pipe.md
Name: clc_encoder_pipe

Overview:
- Two-stage pipelined CLC (column-line code) encoder: 16-bit data word in, 32-bit codeword out (16 data + 16 redundancy bits).
- Codeword layout is exactly the one the CLC decoder consumes; a clean word always yields all-zero line, SP and SDi syndromes.
- Sits directly upstream of the decoder, with valid/ready on both sides.
- Includes a one-shot fault-injection mask so benches and firmware can corrupt a chosen word before it reaches the decoder.

Parameters:
- INJ_EN, 1: 1 enables the fault-injection logic; 0 ignores inj_arm and holds inj_pending at 0.
- CNT_W, 16: width of word_cnt.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  data_in is valid.
- in_ready  out  1  encoder accepts data_in this cycle.
- data_in  in  [0:15]  data word; bit 0 is the MSB.
- out_valid  out  1  code_out is valid.
- out_ready  in  1  downstream accepts code_out.
- code_out  out  [0:31]  codeword; bit 0 is the MSB.
- inj_arm  in  1  single-cycle pulse that latches inj_mask.
- inj_mask  in  [0:31]  XOR mask applied to one future codeword.
- inj_pending  out  1  an armed mask is waiting to be consumed.
- word_cnt  out  [CNT_W-1:0]  count of output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, code_out=0, inj_pending=0, pending mask=0, word_cnt=0, in_ready=1 once reset deasserts. Any words in flight are dropped with no partial output.
- Encoding: let d[i]=data_in[i].
  - code_out[0:15] = d[0:15]; code_out[16+k] = r[k].
  - r0=d0^d2^d5^d7; r1=d9^d11^d12^d14; r2=d1^d3^d4^d6; r3=d8^d10^d13^d15.
  - r4=d0^d1^d4^d5; r5=d10^d11^d14^d15; r6=d2^d3^d6^d7; r7=d8^d9^d12^d13.
  - r8=d0^d8; r9=d4^d12; r10=d1^d9; r11=d5^d13; r12=d2^d10; r13=d6^d14; r14=d3^d11; r15=d7^d15.
- Stage 1 (S1) registers data and the computed r[0:15]. Stage 2 (S2) registers the codeword after injection and drives code_out and out_valid.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv (combinational, no dependence on in_valid).
  - Input accept = in_valid & in_ready: S1 loads and s1_valid=1; otherwise s1_valid clears when s1_adv.
  - S2 loads on s1_adv; s2_valid clears on output handshake with no s1_adv.
- Latency 2 cycles from input accept to out_valid; throughput 1 word/cycle with out_ready held high.
- code_out and out_valid hold stable while out_valid & !out_ready. No bubble insertion, no data loss under any backpressure pattern.
- Injection (INJ_EN=1):
  - inj_arm latches inj_mask into the pending register and sets inj_pending.
  - On the next s1_adv with inj_pending=1, S2 loads codeword ^ pending mask and inj_pending clears.
  - inj_arm in the same cycle as a consuming s1_adv: the advancing word uses the old mask, the new mask becomes pending, and inj_pending stays 1.
  - Re-arming while pending overwrites the mask.
  - An all-zero mask is legal and consumes one word.
- word_cnt increments by 1 on each out_valid & out_ready and wraps from all-ones to 0.

Test Plan:
- Reset, then data_in 0x0000, out_ready=1 -> code_out 0x00000000 exactly 2 cycles after accept; word_cnt=1.
- Words 0x8000, 0x0400, 0xFFFF back-to-back, out_ready=1 -> 0x80008880, 0x04008810, 0xFFFF0000 on consecutive cycles; in_ready stays 1.
- Stream 8 random words with out_ready toggling in a random pattern -> output sequence identical to a reference model, no drops or duplicates. Every codeword fed to the CLC decoder returns the original data.
- inj_arm with mask 0x00000001, then words 0x0000 and 0x0000 -> 0x00000001 then 0x00000000; inj_pending falls on the first word's S1->S2 advance.
- inj_arm with mask 0x00010000 in the same cycle an armed mask 0x80000000 is consumed on word 0x0000 -> 0x80000000. Next word 0x0000 -> 0x00010000.
- Assert rst with both stages full and out_ready=0 -> out_valid=0, word_cnt=0, inj_pending=0 immediately; the first post-reset word emerges clean after 2 cycles.
